// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: default operand width
// and the FSM state encoding.
package shift_add_multiplier_pkg;

    // Default quotient/divisor width.
    localparam int QW_DEFAULT = 6;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // An operation is in progress whenever the FSM is away from IDLE.
    function automatic logic state_busy(input logic [1:0] st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: rebuilds dividend = quotient*divisor+rem
// one multiplier bit per cycle, flags overflow of the 2*QW-bit result and flags
// operand sets that could not have come from a legal division (rem >= divisor).
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int QW = QW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [QW-1:0]     quotient,
    input  logic [QW-1:0]     divisor,
    input  logic [QW:0]       rem,
    output logic [2*QW-1:0]   dividend,
    output logic              ovf,
    output logic              err,
    output logic              busy,
    output logic              done
);

    // Accumulator carries one extra bit so the overflow of the full sum is visible.
    localparam int AW = 2 * QW + 1;
    localparam int CW = $clog2(QW) + 1;

    logic [1:0]    state_r;
    logic          start_d_r;
    logic          armed_r;
    logic [QW-1:0] mult_r;
    logic [AW-1:0] mcand_r;
    logic [AW-1:0] acc_r;
    logic [CW-1:0] cnt_r;
    logic          err_lat_r;

    logic          launch_s;
    logic          last_iter_s;
    logic [AW-1:0] addend_s;
    logic [AW-1:0] acc_next_s;
    logic [1:0]    state_next_s;

    // Launch detection, partial-product adder and next-state decode.
    always_comb begin
        launch_s     = start & ~start_d_r & armed_r & (state_r == ST_IDLE);
        last_iter_s  = (cnt_r == CW'(QW - 1));
        if (mult_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {AW{1'b0}};
        end
        acc_next_s   = acc_r + addend_s;
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    state_next_s = ST_MUL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (last_iter_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Start edge history; armed_r blocks a start held high out of reset
    // from launching until it has been seen low once.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_d_r <= 1'b0;
            armed_r   <= 1'b0;
        end else begin
            start_d_r <= start;
            if (!start) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    // FSM state and iterative datapath; operands are captured once at launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            mult_r    <= {QW{1'b0}};
            mcand_r   <= {AW{1'b0}};
            acc_r     <= {AW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            err_lat_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (launch_s) begin
                        mult_r    <= quotient;
                        mcand_r   <= {{(AW - QW){1'b0}}, divisor};
                        acc_r     <= {{(AW - QW - 1){1'b0}}, rem};
                        cnt_r     <= {CW{1'b0}};
                        err_lat_r <= ({1'b0, divisor} <= rem);
                    end else begin
                        mult_r    <= mult_r;
                        mcand_r   <= mcand_r;
                        acc_r     <= acc_r;
                        cnt_r     <= cnt_r;
                        err_lat_r <= err_lat_r;
                    end
                end
                ST_MUL: begin
                    acc_r   <= acc_next_s;
                    mult_r  <= {1'b0, mult_r[QW-1:1]};
                    mcand_r <= {mcand_r[AW-2:0], 1'b0};
                    cnt_r   <= cnt_r + CW'(1);
                end
                ST_DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // Registered outputs; result and flags change only when entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            dividend <= {(2 * QW){1'b0}};
            ovf      <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= state_busy(state_next_s);
            done <= (state_next_s == ST_DONE);
            if ((state_r == ST_MUL) && last_iter_s) begin
                dividend <= acc_next_s[2*QW-1:0];
                ovf      <= acc_next_s[2*QW];
                err      <= err_lat_r;
            end else begin
                dividend <= dividend;
                ovf      <= ovf;
                err      <= err;
            end
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed scenarios plus random
// operands compared against plain-arithmetic expectations.
module tb_shift_add_multiplier;

    localparam int QW = 6;

    logic            clk;
    logic            rst;
    logic            start;
    logic [QW-1:0]   quotient;
    logic [QW-1:0]   divisor;
    logic [QW:0]     rem;
    logic [2*QW-1:0] dividend;
    logic            ovf;
    logic            err;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier #(.QW(QW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .quotient (quotient),
        .divisor  (divisor),
        .rem      (rem),
        .dividend (dividend),
        .ovf      (ovf),
        .err      (err),
        .busy     (busy),
        .done     (done)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        quotient = 6'($urandom);
        divisor  = 6'($urandom);
        rem      = 7'($urandom);
    endtask

    // One operation: start held for 'hold' sampled edges, optional extra start
    // pulse sampled at edge index 'pulse_at' (edge 1 is the launch edge).
    task automatic do_op(input string tag, input logic [5:0] q, input logic [5:0] d,
                         input logic [6:0] r, input int hold, input int pulse_at);
        int full;
        int edges;
        int lat;
        int busy_cnt;
        int extra;
        full = int'(q) * int'(d) + int'(r);
        @(negedge clk);
        quotient = q;
        divisor  = d;
        rem      = r;
        start    = 1'b1;
        @(posedge clk);
        #1;
        edges    = 1;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (lat == 0 && edges < 20) begin
            @(negedge clk);
            start = (edges < hold || edges == pulse_at) ? 1'b1 : 1'b0;
            scramble();
            @(posedge clk);
            #1;
            edges++;
            if (busy) busy_cnt++;
            if (done) lat = edges;
        end
        check({tag, " latency"},  32'(lat), 32'(QW + 1));
        check({tag, " dividend"}, 32'(dividend), 32'(full % 4096));
        check({tag, " ovf"},      32'(ovf), 32'(full / 4096));
        check({tag, " err"},      32'(err), 32'((r >= {1'b0, d}) ? 1 : 0));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(QW + 1));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, 32'(done), 32'(0));
        check({tag, " idle_after"}, 32'(busy), 32'(0));
        check({tag, " result_held"}, 32'(dividend), 32'(full % 4096));
        extra = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        check({tag, " no_relaunch"}, 32'(extra), 32'(0));
    endtask

    initial begin
        int cnt;
        rst      = 1'b1;
        start    = 1'b1;
        quotient = 6'd0;
        divisor  = 6'd0;
        rem      = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset dividend", 32'(dividend), 32'(0));
        check("reset ovf",      32'(ovf), 32'(0));
        check("reset err",      32'(err), 32'(0));
        check("reset busy",     32'(busy), 32'(0));
        check("reset done",     32'(done), 32'(0));

        // Start held high through reset release must not launch.
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (busy || done) cnt++;
        end
        check("start_held_after_reset", 32'(cnt), 32'(0));
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);

        do_op("s63x11",   6'd63, 6'd11, 7'd0,   1, -1);
        do_op("s54x31",   6'd54, 6'd31, 7'd11,  1, -1);
        do_op("s5x26",    6'd5,  6'd26, 7'd21,  1, -1);
        do_op("s24x1",    6'd24, 6'd1,  7'd0,   1, -1);
        do_op("ovf_err",  6'd63, 6'd63, 7'd127, 1, -1);
        do_op("div0",     6'd0,  6'd0,  7'd5,   1, -1);
        do_op("hold_pulse", 6'd32, 6'd16, 7'd0, 3, 4);

        for (int i = 0; i < 16; i++) begin
            do_op("random", 6'($urandom), 6'($urandom), 7'($urandom), 1, -1);
        end

        // Reset in the third MUL cycle aborts the operation.
        @(negedge clk);
        quotient = 6'd45;
        divisor  = 6'd37;
        rem      = 7'd9;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort dividend", 32'(dividend), 32'(0));
        check("abort ovf",      32'(ovf), 32'(0));
        check("abort err",      32'(err), 32'(0));
        check("abort busy",     32'(busy), 32'(0));
        check("abort done",     32'(done), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
        check("abort no_done", 32'(cnt), 32'(0));
        do_op("post_abort", 6'd45, 6'd37, 7'd9, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
